audio_in_capture: RTL and testbench

//  Reader side of the Audio_Controller sample interface: pops L/R ADC pairs from the

---
 rtl/audio_in_capture.sv | 126 ++++++++++++
 tb/tb_audio_in_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_in_capture.sv
// Capture side of the Audio_Controller: pops L/R pairs, down-mixes to mono, buffers
// them in a local FIFO for a valid/ready consumer, and tracks peak level and overflow.
module audio_in_capture #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8,
  parameter int HOLD_SAMPLES = 16,
  parameter int DECAY_SHIFT  = 4
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              enable,
  input  logic              audio_in_available,
  input  logic [DATA_W-1:0] left_channel_audio_in,
  input  logic [DATA_W-1:0] right_channel_audio_in,
  output logic              read_audio_in,
  output logic [DATA_W-1:0] mono_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [DATA_W-2:0] peak,
  output logic              overflow,
  input  logic              clear_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD_SAMPLES + 1);

  typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

  state_t                    state;
  logic [DATA_W-1:0]         mem [DEPTH];
  logic [AW-1:0]             rd_ptr, wr_ptr;
  logic [CW-1:0]             count;
  logic [HW-1:0]             hold;
  logic signed [DATA_W:0]    sum;
  logic [DATA_W-1:0]         mono;
  logic [DATA_W-2:0]         mag;
  logic                      push, pop, drop;

  always_comb begin
    sum  = {left_channel_audio_in[DATA_W-1], left_channel_audio_in}
         + {right_channel_audio_in[DATA_W-1], right_channel_audio_in};
    mono = DATA_W'(sum >>> 1);
    mag  = mono[DATA_W-2:0];
    if (mono[DATA_W-1]) begin
      // The most negative value has no positive twin; saturate it.
      if (mono[DATA_W-2:0] == '0) mag = '1;
      else                        mag = ~mono[DATA_W-2:0] + 1'b1;
    end
  end

  assign sample_valid = (count != '0);
  assign mono_out     = sample_valid ? mem[rd_ptr] : '0;
  assign pop          = sample_valid && sample_ready;
  assign push         = (state == POP) && ((count < CW'(DEPTH)) || pop);
  assign drop         = (state == POP) && !push;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      read_audio_in <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && audio_in_available) begin
            state         <= POP;
            read_audio_in <= 1'b1;
          end
        end
        POP: begin
          state         <= WAIT;
          read_audio_in <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          read_audio_in <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= mono;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      peak     <= '0;
      hold     <= '0;
      overflow <= 1'b0;
    end else if (clear_status) begin
      peak     <= '0;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (push) begin
        if (mag > peak) begin
          peak <= mag;
          hold <= HW'(HOLD_SAMPLES);
        end else if (hold != '0) begin
          hold <= hold - 1'b1;
        end else begin
          peak <= peak - (peak >> DECAY_SHIFT);
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_in_capture.sv
// Directed self-checking bench for audio_in_capture.
module tb_audio_in_capture;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        available;
  logic [31:0] left, right;
  logic        read_audio_in;
  logic [31:0] mono_out;
  logic        sample_valid;
  logic        sample_ready;
  logic [30:0] peak;
  logic        overflow;
  logic        clear_status;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  audio_in_capture #(.DATA_W(32), .DEPTH(8), .HOLD_SAMPLES(16), .DECAY_SHIFT(4)) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable),
    .audio_in_available(available),
    .left_channel_audio_in(left), .right_channel_audio_in(right),
    .read_audio_in(read_audio_in), .mono_out(mono_out),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .peak(peak), .overflow(overflow), .clear_status(clear_status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (read_audio_in === 1'b1) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the POP cycle; leaves the bench in POP with inputs applied.
  task automatic wait_pop(input logic [31:0] l, input logic [31:0] r);
    int n;
    left = l; right = r; available = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (read_audio_in !== 1'b1 && n < 10);
    checks++;
    if (read_audio_in !== 1'b1) begin
      errors++;
      $display("FAIL pop_timeout: read_audio_in=%b required 1", read_audio_in);
    end
  endtask

  // One complete IDLE->POP->WAIT->IDLE transaction.
  task automatic pair(input logic [31:0] l, input logic [31:0] r);
    wait_pop(l, r);
    tick();
    available = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; available = 1'b0; left = '0; right = '0;
    sample_ready = 1'b0; clear_status = 1'b0;
    tick(); tick();
    checks++;
    if ({read_audio_in, sample_valid, mono_out, peak, overflow} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: rd=%b valid=%b mono=%h peak=%h ovf=%b required all 0",
               read_audio_in, sample_valid, mono_out, peak, overflow);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_first_pair();
    left = 32'd100; right = 32'd300; available = 1'b1; enable = 1'b1;
    tick();
    checks++;
    if (read_audio_in !== 1'b1) begin
      errors++;
      $display("FAIL first_pop_strobe: read_audio_in=%b required 1", read_audio_in);
    end
    tick();
    available = 1'b0;
    checks++;
    if (read_audio_in !== 1'b0 || sample_valid !== 1'b1 || mono_out !== 32'd200 || peak !== 31'd200) begin
      errors++;
      $display("FAIL first_sample: rd=%b valid=%b mono=%0d peak=%0d required 0 1 200 200",
               read_audio_in, sample_valid, mono_out, peak);
    end
    tick();
    sample_ready = 1'b1; tick(); sample_ready = 1'b0;
    checks++;
    if (sample_valid !== 1'b0 || mono_out !== 32'd0) begin
      errors++;
      $display("FAIL first_drain: valid=%b mono=%h required 0 0", sample_valid, mono_out);
    end
  endtask

  task automatic test_mono_mix();
    pair(32'hFFFF_FFFD, 32'd0);
    checks++;
    if (mono_out !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mono_neg_floor: mono=%h required fffffffe", mono_out);
    end
    sample_ready = 1'b1; tick(); sample_ready = 1'b0;
    pair(32'h8000_0000, 32'h8000_0000);
    checks++;
    if (mono_out !== 32'h8000_0000 || peak !== 31'h7FFF_FFFF) begin
      errors++;
      $display("FAIL mono_min: mono=%h peak=%h required 80000000 7fffffff", mono_out, peak);
    end
    sample_ready = 1'b1; tick(); sample_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int base;
    base = pulses;
    for (int k = 1; k <= 8; k++) pair(32'(k * 10), 32'(k * 10));
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_at_full: overflow=%b required 0", overflow);
    end
    pair(32'd90, 32'd90);
    checks++;
    if (overflow !== 1'b1 || pulses - base != 9) begin
      errors++;
      $display("FAIL ovf_drop: overflow=%b pulses=%0d required 1 9", overflow, pulses - base);
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (sample_valid !== 1'b1 || mono_out !== 32'(k * 10)) begin
        errors++;
        $display("FAIL ovf_order_%0d: valid=%b mono=%0d required 1 %0d", k, sample_valid, mono_out, k * 10);
      end
      sample_ready = 1'b1; tick(); sample_ready = 1'b0;
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty: valid=%b required 0", sample_valid);
    end
  endtask

  task automatic test_full_passthrough();
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    for (int k = 0; k < 8; k++) pair(32'(1000 + k), 32'(1000 + k));
    wait_pop(32'd2000, 32'd2000);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0; available = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b0 || mono_out !== 32'd1001) begin
      errors++;
      $display("FAIL full_push_pop: overflow=%b head=%0d required 0 1001", overflow, mono_out);
    end
    pair(32'd5, 32'd5);
    checks++;
    if (overflow !== 1'b1 || peak !== 31'd2000) begin
      errors++;
      $display("FAIL full_drop: overflow=%b peak=%0d required 1 2000", overflow, peak);
    end
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    checks++;
    if (overflow !== 1'b0 || peak !== 31'd0 || sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_status: overflow=%b peak=%0d valid=%b required 0 0 1", overflow, peak, sample_valid);
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (mono_out !== ((k == 8) ? 32'd2000 : 32'(1000 + k))) begin
        errors++;
        $display("FAIL full_order_%0d: mono=%0d required %0d", k, mono_out, (k == 8) ? 2000 : 1000 + k);
      end
      sample_ready = 1'b1; tick(); sample_ready = 1'b0;
    end
  endtask

  task automatic test_peak_decay();
    int base;
    sample_ready = 1'b1;
    pair(32'hFFFF_F9C0, 32'hFFFF_F9C0);
    for (int k = 0; k < 16; k++) pair(32'd0, 32'd0);
    checks++;
    if (peak !== 31'd1600) begin
      errors++;
      $display("FAIL peak_hold: peak=%0d required 1600", peak);
    end
    pair(32'd0, 32'd0);
    checks++;
    if (peak !== 31'd1500) begin
      errors++;
      $display("FAIL peak_decay: peak=%0d required 1500", peak);
    end
    wait_pop(32'd0, 32'd0);
    enable = 1'b0;
    tick(); tick();
    base = pulses;
    repeat (6) tick();
    available = 1'b0;
    checks++;
    if (pulses != base || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_low: extra_pulses=%0d valid=%b required 0 0", pulses - base, sample_valid);
    end
    sample_ready = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset_in_wait();
    for (int k = 1; k <= 3; k++) pair(32'(k), 32'(k));
    wait_pop(32'd7, 32'd7);
    tick();
    resetn = 1'b0;
    #1;
    checks++;
    if ({read_audio_in, sample_valid, mono_out, peak, overflow} !== 66'd0) begin
      errors++;
      $display("FAIL reset_in_wait: rd=%b valid=%b mono=%h peak=%h ovf=%b required all 0",
               read_audio_in, sample_valid, mono_out, peak, overflow);
    end
    available = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_pair();
    test_mono_mix();
    test_overflow();
    test_full_passthrough();
    test_peak_decay();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
